float_fixed_converter: RTL and testbench

Bidirectional, registered converter between IEEE-754 single-precision floats and the 22-bit signed Q2.20 fixed-point format used by the CORDIC datapath. The float-to-fixed path feeds the angle input of the CORDIC stages. The fixed-to-float path converts the CORDIC x result back to a float for the custom-instruction result. Both paths are independent and run concurrently every cycle.

---
 rtl/float_fixed_converter_pkg.sv | 17 +
 rtl/float_fixed_converter_if.sv | 24 ++
 rtl/float_fixed_converter_lod22.sv | 14 +
 rtl/float_fixed_converter.sv | 92 +++++++++
 tb/tb_float_fixed_converter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/float_fixed_converter_pkg.sv
// Shared formats for the float <-> Q2.20 converter: word widths, float fields and
// saturation limits.
package fxp_pkg;

    localparam int unsigned FIX_W    = 22;
    localparam int unsigned FRAC_W   = 20;
    localparam int unsigned FLT_W    = 32;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_BIAS = 127;

    localparam logic [FIX_W-1:0] FIX_MAX = 22'h1FFFFF;
    localparam logic [FIX_W-1:0] FIX_MIN = 22'h200000;

    typedef logic [FIX_W-1:0] q2_20_t;

endpackage

// File: rtl/float_fixed_converter_if.sv
// Operand/result bundle of the converter; both paths are valid-tagged, no back-pressure.
interface float_fixed_converter_if;
    import fxp_pkg::*;

    logic [FLT_W-1:0] fl_in;
    logic             fl_in_valid;
    q2_20_t           fx_out;
    logic             fx_out_valid;
    q2_20_t           fx_in;
    logic             fx_in_valid;
    logic [FLT_W-1:0] fl_out;
    logic             fl_out_valid;

    modport master (
        output fl_in, fl_in_valid, fx_in, fx_in_valid,
        input  fx_out, fx_out_valid, fl_out, fl_out_valid
    );

    modport slave (
        input  fl_in, fl_in_valid, fx_in, fx_in_valid,
        output fx_out, fx_out_valid, fl_out, fl_out_valid
    );

endinterface

// File: rtl/float_fixed_converter_lod22.sv
// 22-bit leading-one detector; returns the index of the highest set bit (0 for zero input).
module lod22 (
    input  logic [21:0] data,
    output logic [4:0]  pos
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < 22; i++) begin
            if (data[i]) pos = 5'(i);
        end
    end

endmodule

// File: rtl/float_fixed_converter.sv
// Registered IEEE-754 single <-> Q2.20 converter; the two paths are independent and each
// has a single output register stage.
module float_fixed_converter
    import fxp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    float_fixed_converter_if.slave  bus
);

    // Float exponent E maps to a right shift of (E_BIAS + 3) - E on {1, m}.
    localparam int unsigned F2X_SHIFT_BASE = EXP_BIAS + MAN_W - FRAC_W;
    localparam int unsigned F2X_MIN_EXP    = EXP_BIAS - FRAC_W;
    localparam int unsigned X2F_EXP_OFS    = EXP_BIAS - FRAC_W;

    logic             f_sign;
    logic [EXP_W-1:0] f_exp;
    logic [MAN_W-1:0] f_man;
    logic [4:0]       f_shamt;
    logic [MAN_W:0]   f_shifted;
    q2_20_t           f_sat;
    q2_20_t           fx_d, fx_q;
    logic             fx_valid_q;

    q2_20_t           x_mag;
    logic [4:0]       x_pos;
    q2_20_t           x_norm;
    logic [EXP_W-1:0] x_exp;
    logic [MAN_W-1:0] x_man;
    logic [FLT_W-1:0] fl_d, fl_q;
    logic             fl_valid_q;

    always_comb begin
        f_sign    = bus.fl_in[FLT_W-1];
        f_exp     = bus.fl_in[FLT_W-2 -: EXP_W];
        f_man     = bus.fl_in[MAN_W-1:0];
        f_shamt   = 5'(8'(F2X_SHIFT_BASE) - f_exp);
        f_shifted = {1'b1, f_man} >> f_shamt;
        f_sat     = f_sign ? FIX_MIN : FIX_MAX;
        fx_d      = '0;
        if (f_exp == '0) begin
            fx_d = '0;
        end else if (f_exp == '1) begin
            fx_d = (f_man != '0) ? '0 : f_sat;
        end else if (f_exp < 8'(F2X_MIN_EXP)) begin
            fx_d = '0;
        end else if (f_exp <= 8'(EXP_BIAS)) begin
            fx_d = f_sign ? q2_20_t'(-f_shifted) : q2_20_t'(f_shifted);
        end else begin
            fx_d = f_sat;
        end
    end

    // -2.0 negates to itself, which reads correctly as an unsigned magnitude of 2^21.
    assign x_mag = bus.fx_in[FIX_W-1] ? q2_20_t'(-bus.fx_in) : bus.fx_in;

    lod22 u_lod (
        .data (x_mag),
        .pos  (x_pos)
    );

    always_comb begin
        x_norm = x_mag << (5'(FIX_W - 1) - x_pos);
        // Drop the hidden one at bit 21; the 21 bits below fill the top of the mantissa.
        x_man  = MAN_W'({x_norm, 2'b00});
        x_exp  = 8'(x_pos) + 8'(X2F_EXP_OFS);
        fl_d   = '0;
        if (bus.fx_in != '0) begin
            fl_d = {bus.fx_in[FIX_W-1], x_exp, x_man};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fx_q       <= '0;
            fx_valid_q <= 1'b0;
            fl_q       <= '0;
            fl_valid_q <= 1'b0;
        end else begin
            fx_q       <= fx_d;
            fx_valid_q <= bus.fl_in_valid;
            fl_q       <= fl_d;
            fl_valid_q <= bus.fx_in_valid;
        end
    end

    assign bus.fx_out       = fx_q;
    assign bus.fx_out_valid = fx_valid_q;
    assign bus.fl_out       = fl_q;
    assign bus.fl_out_valid = fl_valid_q;

endmodule

// File: tb/tb_float_fixed_converter.sv
// Self-checking bench for float_fixed_converter against a real-arithmetic reference model.
module tb_float_fixed_converter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    float_fixed_converter_if bus ();

    float_fixed_converter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value = 1.m * 2^(E-127), scaled by 2^20 and truncated toward zero.
    function automatic logic [21:0] ref_f2x(input logic [31:0] f);
        int unsigned ex = f[30:23];
        int unsigned mn = f[22:0];
        logic [21:0] sat = f[31] ? 22'h200000 : 22'h1FFFFF;
        real         sc;
        int          mag;
        if (ex == 0) return 22'd0;
        if (ex == 255) return (mn != 0) ? 22'd0 : sat;
        sc = (1.0 + real'(mn) / 8388608.0) * (2.0 ** (real'(ex) - 127.0)) * 1048576.0;
        if (sc >= 2097152.0) return sat;
        mag = $rtoi(sc);
        return f[31] ? 22'(-mag) : 22'(mag);
    endfunction

    // Reference: |x| = 2^p + rest, float = {sign, p + 107, rest scaled to 23 bits}.
    function automatic logic [31:0] ref_x2f(input logic [21:0] x);
        int sv  = int'($signed(x));
        int mag = (sv < 0) ? -sv : sv;
        int p   = 0;
        int man;
        if (x == 22'd0) return 32'd0;
        while ((mag >> (p + 1)) != 0) p++;
        man = (mag - (1 << p)) << (23 - p);
        return {x[21], 8'(p + 107), 23'(man)};
    endfunction

    task automatic idle_inputs();
        bus.fl_in       = '0;
        bus.fl_in_valid = 1'b0;
        bus.fx_in       = '0;
        bus.fx_in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.fl_in_valid = 1'b1;
        bus.fx_in_valid = 1'b1;
        bus.fx_in       = 22'h100000;
        bus.fl_in       = 32'h3F800000;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.fx_out, bus.fx_out_valid, bus.fl_out, bus.fl_out_valid} !== 56'd0) begin
                errors++;
                $display("FAIL reset_state cycle %0d: fx_out=%h v=%b fl_out=%h v=%b, want all 0",
                         i, bus.fx_out, bus.fx_out_valid, bus.fl_out, bus.fl_out_valid);
            end
            tick();
        end
        idle_inputs();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.fx_out_valid !== 1'b0 || bus.fl_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: fx_v=%b fl_v=%b, want 0 0",
                     bus.fx_out_valid, bus.fl_out_valid);
        end
    endtask

    task automatic test_f2x_directed();
        logic [31:0] vin [10] = '{32'h3F800000, 32'hBF000000, 32'h80000000, 32'h40400000,
                                  32'hFF800000, 32'h7FC00000, 32'h33D6BF95, 32'h00000001,
                                  32'h7F800000, 32'h3FFFFFFF};
        logic [21:0] vexp [10] = '{22'h100000, 22'h380000, 22'h000000, 22'h1FFFFF,
                                   22'h200000, 22'h000000, 22'h000000, 22'h000000,
                                   22'h1FFFFF, 22'h1FFFFF};
        for (int i = 0; i < 10; i++) begin
            bus.fl_in       = vin[i];
            bus.fl_in_valid = 1'b1;
            tick();
            checks++;
            if (bus.fx_out !== vexp[i] || bus.fx_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL f2x_directed in=%h: got %h v=%b, want %h v=1",
                         vin[i], bus.fx_out, bus.fx_out_valid, vexp[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x2f_directed();
        logic [21:0] vin [7] = '{22'h0C90FD, 22'h100000, 22'h200000, 22'h000001, 22'h000000,
                                 22'h1FFFFF, 22'h3FFFFF};
        logic [31:0] vexp [7] = '{32'h3F490FD0, 32'h3F800000, 32'hC0000000, 32'h35800000,
                                  32'h00000000, 32'h3FFFFFF8, 32'hB5800000};
        for (int i = 0; i < 7; i++) begin
            bus.fx_in       = vin[i];
            bus.fx_in_valid = 1'b1;
            tick();
            checks++;
            if (bus.fl_out !== vexp[i] || bus.fl_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL x2f_directed in=%h: got %h v=%b, want %h v=1",
                         vin[i], bus.fl_out, bus.fl_out_valid, vexp[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_round_trip();
        logic [21:0] x;
        logic [31:0] f;
        for (int i = 0; i < 10000; i++) begin
            x               = 22'($urandom);
            bus.fx_in       = x;
            bus.fx_in_valid = 1'b1;
            tick();
            f = bus.fl_out;
            checks++;
            if (f !== ref_x2f(x)) begin
                errors++;
                $display("FAIL round_trip_x2f in=%h: got %h, want %h", x, f, ref_x2f(x));
            end
            bus.fx_in_valid = 1'b0;
            bus.fl_in       = f;
            bus.fl_in_valid = 1'b1;
            tick();
            checks++;
            if (bus.fx_out !== x) begin
                errors++;
                $display("FAIL round_trip_f2x in=%h via %h: got %h, want %h",
                         x, f, bus.fx_out, x);
            end
            bus.fl_in_valid = 1'b0;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] f;
        logic [21:0] x;
        logic [21:0] exp_fx;
        logic [31:0] exp_fl;
        logic        vf, vx;
        for (int i = 0; i < 2000; i++) begin
            f = $urandom;
            if ($urandom_range(0, 3) != 0) f[30:23] = 8'($urandom_range(100, 132));
            x  = 22'($urandom);
            vf = ($urandom_range(0, 3) != 0);
            vx = ($urandom_range(0, 3) != 0);
            bus.fl_in       = f;
            bus.fl_in_valid = vf;
            bus.fx_in       = x;
            bus.fx_in_valid = vx;
            exp_fx          = ref_f2x(f);
            exp_fl          = ref_x2f(x);
            tick();
            checks++;
            if (bus.fx_out !== exp_fx || bus.fx_out_valid !== vf) begin
                errors++;
                $display("FAIL stream_f2x cyc %0d in=%h: got %h v=%b, want %h v=%b",
                         i, f, bus.fx_out, bus.fx_out_valid, exp_fx, vf);
            end
            checks++;
            if (bus.fl_out !== exp_fl || bus.fl_out_valid !== vx) begin
                errors++;
                $display("FAIL stream_x2f cyc %0d in=%h: got %h v=%b, want %h v=%b",
                         i, x, bus.fl_out, bus.fl_out_valid, exp_fl, vx);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mid_reset();
        bus.fl_in       = 32'h3F800000;
        bus.fl_in_valid = 1'b1;
        bus.fx_in       = 22'h100000;
        bus.fx_in_valid = 1'b1;
        tick();
        checks++;
        if (bus.fx_out_valid !== 1'b1 || bus.fl_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: fx_v=%b fl_v=%b, want 1 1",
                     bus.fx_out_valid, bus.fl_out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.fx_out, bus.fx_out_valid, bus.fl_out, bus.fl_out_valid} !== 56'd0) begin
            errors++;
            $display("FAIL mid_reset_async: fx_out=%h v=%b fl_out=%h v=%b, want all 0",
                     bus.fx_out, bus.fx_out_valid, bus.fl_out, bus.fl_out_valid);
        end
        tick();
        checks++;
        if (bus.fx_out_valid !== 1'b0 || bus.fl_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: fx_v=%b fl_v=%b, want 0 0",
                     bus.fx_out_valid, bus.fl_out_valid);
        end
        idle_inputs();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.fx_out_valid !== 1'b0 || bus.fl_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_stale: fx_v=%b fl_v=%b, want 0 0",
                     bus.fx_out_valid, bus.fl_out_valid);
        end
        bus.fl_in       = 32'hBF000000;
        bus.fl_in_valid = 1'b1;
        bus.fx_in       = 22'h0C90FD;
        bus.fx_in_valid = 1'b1;
        tick();
        checks++;
        if (bus.fx_out !== 22'h380000 || bus.fx_out_valid !== 1'b1 ||
            bus.fl_out !== 32'h3F490FD0 || bus.fl_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_first: fx=%h v=%b fl=%h v=%b, want 380000 1 3f490fd0 1",
                     bus.fx_out, bus.fx_out_valid, bus.fl_out, bus.fl_out_valid);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_f2x_directed();
        test_x2f_directed();
        test_round_trip();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
